// File: rtl/bank_mem_pkg.sv
// Shared constants and types for the four-bank interleaved main memory.
// Address layout: [2:1] bank select, [15:3] per-bank word index, [0] byte bit.
package bank_mem_pkg;

   localparam int unsigned BANK_LAT_DEF = 4;
   localparam int unsigned RD_LAT_DEF   = 2;
   localparam int unsigned NUM_BANKS    = 4;

   localparam int unsigned BANK_LSB = 1;
   localparam int unsigned BANK_MSB = 2;
   localparam int unsigned IDX_LSB  = 3;
   localparam int unsigned IDX_MSB  = 15;

   typedef logic [1:0] bank_id_t;

   localparam int unsigned CTR_W = $clog2(BANK_LAT_DEF + 1);
   typedef logic [CTR_W-1:0] ctr_t;

   function automatic bank_id_t bank_of(logic [15:0] addr);
      return addr[BANK_MSB:BANK_LSB];
   endfunction

endpackage

// File: rtl/banked_main_mem_if.sv
// Request/response bus between the cache controller (master) and the banked memory (slave).
interface banked_main_mem_if
   import bank_mem_pkg::*;
();

   logic [15:0]          addr;
   logic [15:0]          data_in;
   logic                 rd;
   logic                 wr;
   logic [15:0]          data_out;
   logic                 data_vld;
   logic                 stall;
   logic [NUM_BANKS-1:0] busy;
   logic                 err;

   modport master (
      output addr, data_in, rd, wr,
      input  data_out, data_vld, stall, busy, err
   );

   modport slave (
      input  addr, data_in, rd, wr,
      output data_out, data_vld, stall, busy, err
   );

endinterface

// File: rtl/bank_busy_ctr.sv
// Per-bank occupancy countdown: loads BankLat on accept, busy while nonzero.
module bank_busy_ctr
   import bank_mem_pkg::*;
#(
   parameter int unsigned BankLat = BANK_LAT_DEF
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic load_i,
   output logic busy_o
);

   localparam int unsigned CntW = $clog2(BankLat + 1);

   logic [CntW-1:0] cnt_d, cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = CntW'(BankLat);
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign busy_o = (cnt_q != '0);

endmodule

// File: rtl/banked_main_mem.sv
// Four-bank word-interleaved main memory with per-bank occupancy and a fixed-latency read pipe.
// Optional macro BANKMEM_ALIGN_CHECK_EN rejects requests with addr[0] set.
module banked_main_mem
   import bank_mem_pkg::*;
#(
   parameter int unsigned BANK_LAT = BANK_LAT_DEF,
   parameter int unsigned RD_LAT   = RD_LAT_DEF,
   parameter int unsigned IDX_W    = 13
) (
   input logic              clk,
   input logic              rst,
   banked_main_mem_if.slave bus
);

   localparam int unsigned Depth = 2 ** IDX_W;

   bank_id_t             bank;
   logic [IDX_W-1:0]     idx;
   logic                 req;
   logic                 err;
   logic                 stall;
   logic                 accept;
   logic                 rd_accept;
   logic [NUM_BANKS-1:0] busy;
   logic [NUM_BANKS-1:0] load;

   logic [15:0] mem [NUM_BANKS][Depth];

   logic [RD_LAT-1:0] vld_d, vld_q;
   logic [15:0]       dat_d [RD_LAT];
   logic [15:0]       dat_q [RD_LAT];

   assign bank = bank_of(bus.addr);
   assign idx  = bus.addr[IDX_LSB +: IDX_W];

   always_comb begin
      req = bus.rd | bus.wr;
`ifdef BANKMEM_ALIGN_CHECK_EN
      err = (bus.rd & bus.wr) | (req & bus.addr[0]);
`else
      err = bus.rd & bus.wr;
`endif
      // busy is registered, so a counter expiring this cycle still stalls.
      stall     = req & ~err & busy[bank];
      accept    = req & ~err & ~busy[bank];
      rd_accept = accept & bus.rd;
      load      = '0;
      if (accept) begin
         load[bank] = 1'b1;
      end
   end

`ifndef BANKMEM_ALIGN_CHECK_EN
   // Byte bit is don't-care: odd addresses alias the even word.
   logic unused_addr0;
   assign unused_addr0 = bus.addr[0];
`endif

   for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
      bank_busy_ctr #(
         .BankLat (BANK_LAT)
      ) u_busy_ctr (
         .clk_i  (clk),
         .rst_ni (rst),
         .load_i (load[g]),
         .busy_o (busy[g])
      );
   end

   // Array is not reset.
   always_ff @(posedge clk) begin
      if (accept && bus.wr) begin
         mem[bank][idx] <= bus.data_in;
      end
   end

   always_comb begin
      vld_d[0] = rd_accept;
      dat_d[0] = rd_accept ? mem[bank][idx] : 16'h0;
      for (int i = 1; i < RD_LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         dat_d[i] = dat_q[i-1];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= 16'h0;
         end
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < RD_LAT; i++) begin
            dat_q[i] <= dat_d[i];
         end
      end
   end

   // Idle stages carry zero data, so data_out is 0 whenever data_vld is low.
   assign bus.data_vld = vld_q[RD_LAT-1];
   assign bus.data_out = dat_q[RD_LAT-1];
   assign bus.stall    = stall;
   assign bus.err      = err;
   assign bus.busy     = busy;

endmodule

// File: tb/tb_banked_main_mem.sv
// Self-checking bench for banked_main_mem: scoreboard of expected read returns plus
// per-scenario inline checks. Honours BANKMEM_ALIGN_CHECK_EN when defined.
module tb_banked_main_mem;
   import bank_mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   banked_main_mem_if bus ();

   banked_main_mem u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;

   int          n_pass  = 0;
   int          n_total = 0;
   int          cyc     = 0;
   exp_t        sb[$];
   exp_t        mon_e;
   logic [15:0] model [logic [14:0]];

   always @(posedge clk) cyc <= cyc + 1;

   // Scoreboard: every data_vld pulse must match the oldest outstanding read, on time.
   always @(negedge clk) begin
      if (bus.data_vld === 1'b1) begin
         n_total++;
         if (sb.size() == 0) begin
            $display("FAIL rd_unexpected: data_vld=1 data_out=%h at cycle %0d, none expected",
                     bus.data_out, cyc);
         end else begin
            mon_e = sb.pop_front();
            if (bus.data_out !== mon_e.data || cyc != mon_e.cyc) begin
               $display("FAIL rd_data: got %h at cycle %0d, expected %h at cycle %0d",
                        bus.data_out, cyc, mon_e.data, mon_e.cyc);
            end else begin
               n_pass++;
            end
         end
      end else begin
         if (sb.size() != 0 && sb[0].cyc < cyc) begin
            n_total++;
            $display("FAIL rd_missing: expected %h at cycle %0d, no data_vld by cycle %0d",
                     sb[0].data, sb[0].cyc, cyc);
            void'(sb.pop_front());
         end
         if (bus.data_out !== 16'h0) begin
            n_total++;
            $display("FAIL data_out_idle: data_out=%h with data_vld=0, expected 0000",
                     bus.data_out);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, %0d/%0d so far", n_pass, n_total);
      $fatal(1);
   end

   // Starts at posedge+1; drives, checks err at +2, waits out stalls, returns at posedge+1.
   task automatic issue(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input bit push, output bit acc,
                        output int waits);
      bit          exp_err;
      logic [14:0] key;
      exp_err = r & w;
`ifdef BANKMEM_ALIGN_CHECK_EN
      exp_err = exp_err | ((r | w) & a[0]);
`endif
      key         = a[15:1];
      acc         = 1'b0;
      waits       = 0;
      bus.addr    = a;
      bus.data_in = d;
      bus.rd      = r;
      bus.wr      = w;
      #1;
      n_total++;
      if (bus.err !== exp_err) begin
         $display("FAIL err_flag: addr=%h rd=%b wr=%b err=%b expected %b", a, r, w, bus.err,
                  exp_err);
      end else begin
         n_pass++;
      end
      if (exp_err) begin
         n_total++;
         if (bus.stall !== 1'b0) begin
            $display("FAIL err_stall: addr=%h stall=%b expected 0", a, bus.stall);
         end else begin
            n_pass++;
         end
         @(posedge clk);
         #1;
         bus.rd = 1'b0;
         bus.wr = 1'b0;
         return;
      end
      while (bus.stall === 1'b1 && waits < 12) begin
         @(posedge clk);
         #2;
         waits++;
      end
      if (bus.stall !== 1'b0) begin
         n_total++;
         $display("FAIL stall_timeout: addr=%h stall=%b after %0d cycles, expected 0", a,
                  bus.stall, waits);
         bus.rd = 1'b0;
         bus.wr = 1'b0;
         return;
      end
      acc = 1'b1;
      if (r && push) sb.push_back('{data: model[key], cyc: cyc + int'(RD_LAT_DEF)});
      if (w) model[key] = d;
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      bus.wr = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      @(posedge clk);
      #1;
      n_total++;
      if (bus.busy !== 4'b0000 || bus.data_vld !== 1'b0 || bus.data_out !== 16'h0 ||
          bus.stall !== 1'b0 || bus.err !== 1'b0) begin
         $display("FAIL reset_state: busy=%b vld=%b dout=%h stall=%b err=%b, expected all 0",
                  bus.busy, bus.data_vld, bus.data_out, bus.stall, bus.err);
      end else begin
         n_pass++;
      end
      rst = 1'b1;
   endtask

   task automatic test_write_read();
      bit acc;
      int waits;
      issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, 1'b0, acc, waits);
      for (int i = 1; i <= 4; i++) begin
         #1;
         n_total++;
         if (bus.busy[0] !== 1'b1) begin
            $display("FAIL busy_window: cycle W+%0d busy[0]=%b expected 1", i, bus.busy[0]);
         end else begin
            n_pass++;
         end
         @(posedge clk);
         #1;
      end
      #1;
      n_total++;
      if (bus.busy[0] !== 1'b0) begin
         $display("FAIL busy_release: cycle W+5 busy[0]=%b expected 0", bus.busy[0]);
      end else begin
         n_pass++;
      end
      #1;
      issue(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, acc, waits);
      n_total++;
      if (!acc || waits != 0) begin
         $display("FAIL read_after_window: accepted=%b waits=%0d expected 1/0", acc, waits);
      end else begin
         n_pass++;
      end
      idle(4);
   endtask

   task automatic test_stall();
      bit acc;
      int waits;
      issue(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0, acc, waits);
      bus.addr = 16'h0010;
      bus.rd   = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         #1;
         n_total++;
         if (bus.stall !== 1'b1) begin
            $display("FAIL same_bank_stall: cycle W+%0d stall=%b expected 1", i, bus.stall);
         end else begin
            n_pass++;
         end
         @(posedge clk);
         #1;
      end
      #1;
      n_total++;
      if (bus.stall !== 1'b0) begin
         $display("FAIL stall_release: cycle W+5 stall=%b expected 0", bus.stall);
      end else begin
         n_pass++;
         sb.push_back('{data: model[15'h0008], cyc: cyc + int'(RD_LAT_DEF)});
      end
      @(posedge clk);
      #1;
      bus.rd = 1'b0;
      idle(4);
   endtask

   task automatic test_back_to_back();
      bit acc;
      int waits;
      for (int i = 0; i < 4; i++) begin
         issue(1'b0, 1'b1, 16'(2 * i), 16'(i + 1), 1'b0, acc, waits);
      end
      idle(5);
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 1'b0, 16'(2 * i), 16'h0, 1'b1, acc, waits);
         n_total++;
         if (!acc || waits != 0) begin
            $display("FAIL interleave_stall: bank %0d accepted=%b waits=%0d expected 1/0", i,
                     acc, waits);
         end else begin
            n_pass++;
         end
      end
      #1;
      n_total++;
      if (bus.busy !== 4'b1111) begin
         $display("FAIL busy_peak: busy=%b expected 1111", bus.busy);
      end else begin
         n_pass++;
      end
      idle(5);
   endtask

   task automatic test_err();
      bit acc;
      int waits;
      issue(1'b0, 1'b1, 16'h0020, 16'hAAAA, 1'b0, acc, waits);
      idle(5);
      issue(1'b1, 1'b1, 16'h0020, 16'h5555, 1'b0, acc, waits);
      #1;
      n_total++;
      if (bus.busy !== 4'b0000) begin
         $display("FAIL err_no_busy: busy=%b expected 0000", bus.busy);
      end else begin
         n_pass++;
      end
      #1;
      issue(1'b1, 1'b0, 16'h0020, 16'h0, 1'b1, acc, waits);
      idle(4);
   endtask

   task automatic test_reset_inflight();
      bit acc;
      int waits;
      issue(1'b0, 1'b1, 16'h0040, 16'h7777, 1'b0, acc, waits);
      idle(5);
      issue(1'b1, 1'b0, 16'h0040, 16'h0, 1'b0, acc, waits);
      rst = 1'b0;
      #1;
      n_total++;
      if (bus.busy !== 4'b0000 || bus.data_vld !== 1'b0) begin
         $display("FAIL reset_inflight: busy=%b vld=%b expected 0000/0", bus.busy,
                  bus.data_vld);
      end else begin
         n_pass++;
      end
      #1;
      idle(3);
      rst = 1'b1;
      issue(1'b1, 1'b0, 16'h0040, 16'h0, 1'b1, acc, waits);
      n_total++;
      if (!acc || waits != 0) begin
         $display("FAIL post_reset_accept: accepted=%b waits=%0d expected 1/0", acc, waits);
      end else begin
         n_pass++;
      end
      idle(4);
   endtask

   task automatic test_align();
      bit acc;
      int waits;
      issue(1'b0, 1'b1, 16'h0010, 16'h1111, 1'b0, acc, waits);
      issue(1'b0, 1'b1, 16'h0011, 16'h2222, 1'b0, acc, waits);
      idle(5);
      issue(1'b1, 1'b0, 16'h0010, 16'h0, 1'b1, acc, waits);
      idle(4);
   endtask

   initial begin
      bus.addr    = 16'h0;
      bus.data_in = 16'h0;
      bus.rd      = 1'b0;
      bus.wr      = 1'b0;
      test_reset();
      test_write_read();
      test_stall();
      test_back_to_back();
      test_err();
      test_reset_inflight();
      test_align();
      idle(4);
      n_total++;
      if (sb.size() != 0) begin
         $display("FAIL sb_drain: %0d reads outstanding, expected 0", sb.size());
      end else begin
         n_pass++;
      end
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/banked_main_mem.md
Name: banked_main_mem

Overview:
- Four-bank, word-interleaved main memory model directly downstream of the direct-mapped cache controller FSM.
- Consumes its rd/wr strobes, address (with the FSM's mem offset in addr[2:1]) and write data.
- Produces read data, per-bank busy flags, stall and err.
- Banks are independently pipelined, so one access can start per cycle while each bank stays occupied for a fixed window.

Parameters:
- BANK_LAT, 4: cycles a bank reports busy after accepting an access.
- RD_LAT, 2: cycles from read acceptance to data_out valid (must be ≤ BANK_LAT).
- IDX_W, 13: per-bank word index width (addr[15:3]); bank depth = 2^IDX_W words.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- addr  in  16  byte address; [2:1] bank select, [15:3] word index, [0] byte bit
- data_in  in  16  write data
- rd  in  1  read request
- wr  in  1  write request
- data_out  out  16  read data, valid for exactly one cycle, 0 otherwise
- data_vld  out  1  data_out valid strobe
- stall  out  1  combinational; request not accepted this cycle
- busy  out  4  per-bank occupied flags, registered
- err  out  1  combinational; illegal request this cycle

Behaviour:
- Reset (rst low, async): busy=0, data_out=0, data_vld=0, read pipeline cleared, counters cleared. Array contents are not reset. All in-flight reads are dropped.
- Request present: req = rd | wr. Target bank b = addr[2:1].
- err = rd & wr (plus alignment, see optional feature). An err request is never accepted and has no side effects.
- stall = req & ~err & busy[b].
- Accept in cycle N when req & ~err & ~stall.
- Bank occupancy:
  - On accept, bank b's counter loads BANK_LAT; busy[b]=1 in cycles N+1 .. N+BANK_LAT.
  - Counter decrements each cycle; busy[b] = (counter != 0).
  - A same-bank request in N+1..N+BANK_LAT stalls. A same-bank request at N+BANK_LAT+1 is accepted.
- Writes: the array word [b][addr[15:3]] is updated at the accepting edge (end of cycle N).
- Reads:
  - The array is read at the accepting edge into pipeline stage 1, then shifted through RD_LAT-1 register stages.
  - data_out/data_vld assert in cycle N+RD_LAT for one cycle only.
  - With the defaults, data is sampled at N and appears at N+2.
- Concurrency:
  - Up to 4 accesses in flight (one per bank), one accept per cycle.
  - Back-to-back reads to banks 0,1,2,3 in cycles N..N+3 return data in N+2..N+5, in order.
  - Reads in consecutive cycles produce consecutive data_vld pulses; there is no output collision because at most one read is accepted per cycle.
- Simultaneous events:
  - A bank counter reaching 0 in the same cycle as a new same-bank request: busy is registered, so the request is judged on the current busy value. Stall if busy[b]=1 this cycle.
  - rd & wr together: err=1, stall=0, busy unchanged.
- Illegal/idle: with no request, stall=0 and err=0. Outputs drain the pipeline normally.
- The requester must hold addr/data/rd/wr stable while stall=1. The block does not queue.

Optional Feature:
- Macro BANKMEM_ALIGN_CHECK_EN.
- Defined: err additionally asserts when req & addr[0]. The request is rejected (no write, no read, no busy).
- Undefined: addr[0] is ignored and an odd address accesses the same word as the even address.

Decomposition:
- Package bank_mem_pkg holds:
  - BANK_LAT and RD_LAT defaults
  - NUM_BANKS = 4
  - bank-select field position [2:1] and index field [15:3] constants
  - bank-id typedef (2 bits)
  - counter typedef sized to hold BANK_LAT
- Sub-module bank_busy_ctr (one per bank, instantiated 4×):
  - Inputs: load strobe.
  - Behaviour: countdown counter, async active-low reset.
  - Output: busy.
- Storage and the read pipeline stay in the top module.

Test Plan:
- Write 0xBEEF @0x0010 (bank 0), then read @0x0010 at N = 5 cycles later: data_vld=1 and data_out=0xBEEF at N+2 only. busy[0] high N+1..N+4.
- Write @0x0010, then read @0x0010 the next cycle: stall=1 for cycles 1..4 after the write. Read accepted at cycle 5. Returns written value.
- Reads @0x0000, 0x0002, 0x0004, 0x0006 on 4 consecutive cycles (previously written 1,2,3,4): no stalls. data_out = 1,2,3,4 on 4 consecutive cycles starting 2 cycles after the first read. busy=4'b1111 at peak.
- rd=wr=1 @0x0020: err=1, stall=0, busy stays 0, no data_vld. A later read @0x0020 returns the old contents.
- Read accepted, then rst pulled low the next cycle: busy=0 and data_vld never pulses. After release, a request to the same bank is accepted immediately.
- With BANKMEM_ALIGN_CHECK_EN, write @0x0011: err=1 and the word at 0x0010 is unchanged. Without the macro: the word at 0x0010 is updated.
